// File: rtl/exp_pkg.sv
// ---------------------------------------------------------------------------
// exp_pkg : shared types and constants for the exponential / softmax stages
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package exp_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        RECIP = 2'd1,
        EMIT  = 2'd2
    } softmax_state_t;

    localparam int  SOFTMAX_MAX_LEN_DEF = 16;
    localparam real ZERO_R              = 0.0;
    localparam real ONE_R               = 1.0;

endpackage : exp_pkg

`default_nettype wire

// File: rtl/softmax_buf.sv
// ---------------------------------------------------------------------------
// softmax_buf : MAX_LEN-deep real storage, one write port, async read port
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module softmax_buf #(
    parameter int MAX_LEN = 16,
    parameter int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  real              wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output real              rdata_o
);

    // Contents are don't-care after reset, so the array carries no reset.
    real mem_q [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : softmax_buf

`default_nettype wire

// File: rtl/softmax_norm.sv
// ---------------------------------------------------------------------------
// softmax_norm : buffers one vector of exp() values and streams value / sum
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module softmax_norm
    import exp_pkg::*;
#(
    parameter int MAX_LEN = SOFTMAX_MAX_LEN_DEF,
    parameter int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic           clk,
    input  logic           rst,
    input  real            in_val,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_last,
    output real            out_val,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last,
    output logic [IDX_W:0] vec_len,
    output logic           busy,
    output logic           err_zero_sum,
    output logic           err_overflow
);

    localparam logic [IDX_W:0] c_one      = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] c_last_idx = (IDX_W+1)'(MAX_LEN - 1);

    softmax_state_t state_q, state_d;
    logic [IDX_W:0] count_q, count_d;
    logic [IDX_W:0] rd_idx_q, rd_idx_d;
    logic [IDX_W:0] vec_len_q, vec_len_d;
    real            sum_q, sum_d;
    real            recip_q, recip_d;
    real            out_val_q, out_val_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic           err_zs_q, err_zs_d;
    logic           err_ov_q, err_ov_d;
    logic           live_q;

    logic           w_in_xfer;
    logic           w_buf_we;
    real            w_buf_rdata;

    softmax_buf #(
        .MAX_LEN (MAX_LEN),
        .IDX_W   (IDX_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (w_buf_we),
        .waddr_i (count_q[IDX_W-1:0]),
        .wdata_i (in_val),
        .raddr_i (rd_idx_q[IDX_W-1:0]),
        .rdata_o (w_buf_rdata)
    );

    // live_q keeps in_ready low until the first edge after reset release.
    assign in_ready  = (state_q == ACCUM) && live_q;
    assign w_in_xfer = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_idx_d    = rd_idx_q;
        vec_len_d   = vec_len_q;
        sum_d       = sum_q;
        recip_d     = recip_q;
        out_val_d   = out_val_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_zs_d    = err_zs_q;
        err_ov_d    = err_ov_q;
        w_buf_we    = 1'b0;

        case (state_q)
            ACCUM: begin
                if (w_in_xfer) begin
                    w_buf_we = 1'b1;
                    sum_d    = sum_q + in_val;
                    count_d  = count_q + c_one;
                    if (in_last || (count_q == c_last_idx)) begin
                        vec_len_d = count_q + c_one;
                        state_d   = RECIP;
                        if (!in_last) begin
                            err_ov_d = 1'b1;
                        end
                    end
                end
            end

            RECIP: begin
                if (sum_q > ZERO_R) begin
                    recip_d  = ONE_R / sum_q;
                    err_zs_d = 1'b0;
                end else begin
                    recip_d  = ZERO_R;
                    err_zs_d = 1'b1;
                end
                rd_idx_d = '0;
                state_d  = EMIT;
            end

            EMIT: begin
                // rd_idx_q points at the next element to load into the output register.
                if (out_valid_q && out_ready && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    count_d     = '0;
                    sum_d       = ZERO_R;
                    state_d     = ACCUM;
                end else if (!out_valid_q || out_ready) begin
                    out_valid_d = 1'b1;
                    out_val_d   = w_buf_rdata * recip_q;
                    out_last_d  = (rd_idx_q == (vec_len_q - c_one));
                    rd_idx_d    = rd_idx_q + c_one;
                end
            end

            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            rd_idx_q    <= '0;
            vec_len_q   <= '0;
            sum_q       <= ZERO_R;
            recip_q     <= ZERO_R;
            out_val_q   <= ZERO_R;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_zs_q    <= 1'b0;
            err_ov_q    <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_idx_q    <= rd_idx_d;
            vec_len_q   <= vec_len_d;
            sum_q       <= sum_d;
            recip_q     <= recip_d;
            out_val_q   <= out_val_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_zs_q    <= err_zs_d;
            err_ov_q    <= err_ov_d;
            live_q      <= 1'b1;
        end
    end

    assign out_val      = out_val_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign vec_len      = vec_len_q;
    assign busy         = !((state_q == ACCUM) && (count_q == '0));
    assign err_zero_sum = err_zs_q;
    assign err_overflow = err_ov_q;

endmodule : softmax_norm

`default_nettype wire

// File: doc/softmax_norm.md
Name: softmax_norm

Overview:
- Downstream consumer of the exponential stage. Accepts a stream of exp() results forming one vector, terminated by in_last.
- Buffers each value and accumulates the running sum. Then streams out every value divided by that sum, i.e. the softmax normalisation.
- Data stays in the `real` domain, same as the exponential stage. This is a behavioural-model block, not a synthesis target.

Parameters:
- MAX_LEN, 16, maximum vector length held in the buffer (must be ≥2).
- IDX_W, $clog2(MAX_LEN), width of buffer index and count.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_val  input  real  exp() value from the upstream exponential stage.
- in_valid  input  1  in_val present.
- in_ready  output  1  block can accept in_val this cycle.
- in_last  input  1  marks final element of the vector; qualified by in_valid.
- out_val  output  real  normalised value buf[i] / sum.
- out_valid  output  1  out_val present.
- out_ready  input  1  downstream accepts out_val.
- out_last  output  1  final normalised element; qualified by out_valid.
- vec_len  output  IDX_W+1  number of elements in the current/last vector.
- busy  output  1  high in any state other than ACCUM-with-zero-count.
- err_zero_sum  output  1  sticky; sum was ≤ 0.0 for the last vector.
- err_overflow  output  1  sticky; MAX_LEN elements received without in_last.

Behaviour:
- Reset (async, rst=1):
  - state=ACCUM, count=0, sum=0.0, recip=0.0, rd_idx=0.
  - in_ready=0 while rst is high, 1 from the first clk edge after release.
  - out_valid=0, out_last=0, out_val=0.0, vec_len=0, busy=0.
  - Both error flags cleared. Buffer contents are don't-care.
  - Reset mid-vector discards all partial input and output; nothing is emitted afterwards.
- Handshake: a transfer occurs when valid && ready at posedge. out_val and out_last are held stable while out_valid && !out_ready.
- States:
  - ACCUM:
    - in_ready=1.
    - On input transfer: buf[count]=in_val, sum+=in_val, count++.
    - On in_last, or on count reaching MAX_LEN: latch vec_len=count+1, go to RECIP.
    - Reaching MAX_LEN without in_last sets err_overflow. Any further input is held off (in_ready=0) until the next ACCUM.
  - RECIP:
    - One cycle, in_ready=0.
    - If sum > 0.0: recip=1.0/sum, err_zero_sum=0. Otherwise recip=0.0 and err_zero_sum=1.
    - rd_idx=0. Go to EMIT.
  - EMIT:
    - in_ready=0. out_valid=1, out_val=buf[rd_idx]*recip, out_last=(rd_idx==vec_len-1), all registered.
    - On output transfer: rd_idx++. On transfer with out_last: out_valid=0 next cycle, count=0, sum=0.0, go to ACCUM.
- Latency:
  - Input transfer of last element at edge T. RECIP runs during cycle T..T+1.
  - First out_valid is high after edge T+2.
  - With out_ready held 1, one output per cycle. in_ready returns 1 the cycle after the out_last transfer.
- No overlap: a new vector is never accepted while EMIT is active.
- Single-element vector (in_last on first transfer): output is buf[0]/buf[0] = 1.0 with out_last=1.
- Error flags persist until reset or until the next RECIP rewrites err_zero_sum. err_overflow clears only on reset.
- Negative inputs are passed through arithmetically. Only the sum ≤ 0.0 check is enforced.

Decomposition:
- Package exp_pkg:
  - `typedef enum {ACCUM, RECIP, EMIT} softmax_state_t`.
  - `localparam int SOFTMAX_MAX_LEN_DEF = 16`.
  - Shared `real` constants ZERO_R = 0.0, ONE_R = 1.0.
- Sub-module softmax_buf: MAX_LEN-deep real register array, one write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
- All control, sum and reciprocal logic stays in softmax_norm.

Test Plan:
- Basic vector: in_val 1.0, 1.0, 2.0 (last on 3rd), out_ready=1 → out_val 0.25, 0.25, 0.5; out_last on 3rd; vec_len=3; first out_valid 2 cycles after the last input edge.
- Back-pressure: same vector, out_ready toggled 1,0,0,1,1 → each out_val held stable while stalled; exactly 3 transfers; in_ready=0 until the out_last transfer completes.
- Zero sum: 0.0, 0.0 (last) → outputs 0.0, 0.0; err_zero_sum=1. Next vector 3.0 (last) → output 1.0, err_zero_sum=0.
- Overflow: MAX_LEN=4, send 1.0×5 with no in_last → 4 accepted, 5th stalled (in_ready=0); err_overflow=1; outputs 0.25×4 with out_last on 4th.
- Reset mid-EMIT: after 1st output of vector 2.0, 2.0 (last), assert rst asynchronously → out_valid drops immediately, vec_len=0, in_ready=0 during reset. After release, vector 5.0 (last) → single output 1.0.
- Single element: in_val 7.389 with in_last → out_val 1.0, out_last=1, vec_len=1.
